updown_counter_chk: RTL and testbench

//   Parametrised up/down counter with synchronous load, wrap or saturate mode,
//   and built-in protocol/range checkers that raise a sticky error with a code.
//   It is the general successor to the fixed 3-bit inc/ld counter, and is used

---
 rtl/updown_counter_chk_pkg.sv | 33 +++
 rtl/updown_counter_chk_if.sv | 29 ++
 rtl/updown_counter_chk_checker.sv | 82 ++++++++
 rtl/updown_counter_chk.sv | 95 +++++++++
 tb/tb_updown_counter_chk.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/updown_counter_chk_pkg.sv
// Shared error codes, counting modes and the error-priority helper for the
// self-checking up/down counter.
package counter_pkg;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CONFLICT = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_OVF      = 2'd3
    } err_code_t;

    // A corrupted step reports under the overflow code.
    localparam err_code_t ERR_STEP = ERR_OVF;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic err_code_t lowestCode(input logic conflictFire,
                                             input logic rangeFire,
                                             input logic ovfFire);
        err_code_t result;
        result = ERR_NONE;
        if (conflictFire) begin
            result = ERR_CONFLICT;
        end else if (rangeFire) begin
            result = ERR_RANGE;
        end else if (ovfFire) begin
            result = ERR_OVF;
        end
        return result;
    endfunction

endpackage

// File: rtl/updown_counter_chk_if.sv
// Control/status bundle of the up/down counter; the counter is the slave,
// whoever drives the requests is the master.
interface updown_counter_chk_if
    import counter_pkg::*;
#(
    parameter int WIDTH = 3
);
    logic             ld;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] data_in;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             at_max;
    logic             at_min;
    logic             wrap;
    logic             error;
    err_code_t        err_code;

    modport master (
        output ld, inc, dec, data_in, clr_err,
        input  data_out, at_max, at_min, wrap, error, err_code
    );

    modport slave (
        input  ld, inc, dec, data_in, clr_err,
        output data_out, at_max, at_min, wrap, error, err_code
    );
endinterface

// File: rtl/updown_counter_chk_checker.sv
// Conflict, range and step checkers plus sticky error capture for the counter.
// The shadow register remembers the previous count so illegal jumps are caught.
module counter_checker
    import counter_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic             ovf_i,
    input  logic             clr_err_i,
    output logic             error_o,
    output err_code_t        err_code_o
);

    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH-1:0] prev_q;
    logic             skip_q;
    logic             error_q, error_d;
    err_code_t        code_q, code_d;

    logic [WIDTH:0] curExt, prevExt;
    logic           conflictFire, rangeFire, stepOk, stepFire;
    err_code_t      newCode;

    assign curExt  = {1'b0, count_i};
    assign prevExt = {1'b0, prev_q};

    assign conflictFire = ld_i & (inc_i | dec_i);
    assign rangeFire    = ld_i & ({1'b0, data_in_i} > MAX_EXT);

    // Only the wrap mode may jump between the two bounds in one step.
    assign stepOk = (curExt == prevExt)
                  || (curExt == prevExt + ONE_EXT)
                  || (curExt + ONE_EXT == prevExt)
                  || ((SATURATE == MODE_WRAP)
                      && (((prevExt == MAX_EXT) && (curExt == '0))
                          || ((prevExt == '0) && (curExt == MAX_EXT))));
    assign stepFire = ~skip_q & ~stepOk;

    assign newCode = lowestCode(conflictFire, rangeFire, ovf_i | stepFire);

    // A new firing beats a simultaneous clear; otherwise the first code sticks.
    always_comb begin
        error_d = error_q;
        code_d  = code_q;
        if ((newCode != ERR_NONE) && (!error_q || clr_err_i)) begin
            error_d = 1'b1;
            code_d  = newCode;
        end else if (clr_err_i) begin
            error_d = 1'b0;
            code_d  = ERR_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q  <= '0;
            skip_q  <= 1'b1;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            prev_q  <= count_i;
            skip_q  <= ld_i;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    assign error_o    = error_q;
    assign err_code_o = code_q;

endmodule

// File: rtl/updown_counter_chk.sv
// Bounded up/down counter with load, wrap or saturate at the bounds, and a
// built-in checker that latches the first protocol or range error.
module updown_counter_chk
    import counter_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = MODE_WRAP
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_counter_chk_if.slave  bus
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovfFire;
    logic [WIDTH:0]   cntExt;

    assign cntExt = {1'b0, count_q};

    // Load beats counting; inc and dec together cancel out.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovfFire = 1'b0;
        if (bus.ld) begin
            if ({1'b0, bus.data_in} > MAX_EXT) begin
                count_d = MAX_VAL;
            end else begin
                count_d = bus.data_in;
            end
        end else if (bus.inc && !bus.dec) begin
            if (cntExt >= MAX_EXT) begin
                wrap_d = 1'b1;
                if (SATURATE == MODE_SAT) begin
                    ovfFire = 1'b1;
                end else begin
                    count_d = '0;
                end
            end else begin
                count_d = WIDTH'(cntExt + ONE_EXT);
            end
        end else if (bus.dec && !bus.inc) begin
            if (cntExt == '0) begin
                wrap_d = 1'b1;
                if (SATURATE == MODE_SAT) begin
                    ovfFire = 1'b1;
                end else begin
                    count_d = MAX_VAL;
                end
            end else begin
                count_d = WIDTH'(cntExt - ONE_EXT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    counter_checker #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .SATURATE  (SATURATE)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .ld_i       (bus.ld),
        .inc_i      (bus.inc),
        .dec_i      (bus.dec),
        .data_in_i  (bus.data_in),
        .count_i    (count_q),
        .ovf_i      (ovfFire),
        .clr_err_i  (bus.clr_err),
        .error_o    (bus.error),
        .err_code_o (bus.err_code)
    );

    assign bus.data_out = count_q;
    assign bus.at_max   = (cntExt == MAX_EXT);
    assign bus.at_min   = (count_q == '0);
    assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_updown_counter_chk.sv
// Drives three counter configurations (wrap/7, saturate/5, wrap/5) with the
// same stimulus and compares each against an integer reference model.
module tb_updown_counter_chk;
    import counter_pkg::*;

    localparam int W  = 3;
    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         ld = 1'b0, inc = 1'b0, dec = 1'b0, clr = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0] obsCnt [NI];
    logic         obsMax [NI];
    logic         obsMin [NI];
    logic         obsWrap[NI];
    logic         obsErr [NI];
    logic [1:0]   obsCode[NI];

    int mCnt [NI];
    bit mWrap[NI];
    bit mErr [NI];
    int mCode[NI];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gInst
        updown_counter_chk_if #(.WIDTH(W)) bus ();

        assign bus.ld      = ld;
        assign bus.inc     = inc;
        assign bus.dec     = dec;
        assign bus.data_in = din;
        assign bus.clr_err = clr;

        assign obsCnt[g]  = bus.data_out;
        assign obsMax[g]  = bus.at_max;
        assign obsMin[g]  = bus.at_min;
        assign obsWrap[g] = bus.wrap;
        assign obsErr[g]  = bus.error;
        assign obsCode[g] = bus.err_code;

        updown_counter_chk #(
            .WIDTH     (W),
            .MAX_COUNT ((g == 0) ? 7 : 5),
            .SATURATE  ((g == 1) ? MODE_SAT : MODE_WRAP)
        ) dut (
            .clk (clk),
            .rst (rstn),
            .bus (bus)
        );
    end

    function automatic int maxOf(input int i);
        return (i == 0) ? 7 : 5;
    endfunction

    function automatic bit satOf(input int i);
        return (i == 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour: plain integer counting, errors collected by priority.
    task automatic modelStep(input bit r, input bit l, input bit up, input bit dn,
                             input int d, input bit c);
        for (int i = 0; i < NI; i++) begin
            int fired;
            fired = 0;
            if (!r) begin
                mCnt[i] = 0; mWrap[i] = 0; mErr[i] = 0; mCode[i] = 0;
                continue;
            end
            mWrap[i] = 0;
            if (l) begin
                if (up || dn) fired = 1;
                if (d > maxOf(i)) begin
                    mCnt[i] = maxOf(i);
                    if (fired == 0) fired = 2;
                end else begin
                    mCnt[i] = d;
                end
            end else if (up != dn) begin
                int nxt;
                nxt = up ? mCnt[i] + 1 : mCnt[i] - 1;
                if (nxt > maxOf(i) || nxt < 0) begin
                    mWrap[i] = 1;
                    if (satOf(i)) fired = 3;
                    else mCnt[i] = (nxt < 0) ? maxOf(i) : 0;
                end else begin
                    mCnt[i] = nxt;
                end
            end
            if (fired != 0 && (!mErr[i] || c)) begin
                mErr[i] = 1; mCode[i] = fired;
            end else if (c) begin
                mErr[i] = 0; mCode[i] = 0;
            end
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("u%0d.data_out", i), obsCnt[i], mCnt[i]);
            checkOutput($sformatf("u%0d.at_max", i), obsMax[i], (mCnt[i] == maxOf(i)));
            checkOutput($sformatf("u%0d.at_min", i), obsMin[i], (mCnt[i] == 0));
            checkOutput($sformatf("u%0d.wrap", i), obsWrap[i], mWrap[i]);
            checkOutput($sformatf("u%0d.error", i), obsErr[i], mErr[i]);
            checkOutput($sformatf("u%0d.err_code", i), obsCode[i], mCode[i]);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit l, input bit up, input bit dn,
                                 input int d, input bit c);
        @(negedge clk);
        rstn = r; ld = l; inc = up; dec = dn; din = W'(d); clr = c;
        @(posedge clk);
        modelStep(r, l, up, dn, d, c);
        #1;
        compareAll();
    endtask

    initial begin
        int wraps;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 5, 0);

        // Ten increments from zero.
        wraps = 0;
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1, 0, 1, 0, 0, 0);
            if (obsWrap[0]) wraps++;
        end
        checkOutput("t1.wrapCount", wraps, 1);
        checkOutput("t1.final", obsCnt[0], 2);
        checkOutput("t2.satHold", obsCnt[1], 5);
        checkOutput("t2.ovfCode", obsCode[1], 3);

        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("t2.decAfterSat", obsCnt[1], 4);

        // Out-of-range load, then clear.
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 6, 0);
        checkOutput("t3.clamp", obsCnt[1], 5);
        checkOutput("t3.rangeCode", obsCode[1], 2);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("t3.cleared", obsErr[1], 0);

        // Load/inc conflict, then a later range error must not overwrite it.
        applyStimulus(1, 1, 1, 0, 3, 0);
        checkOutput("t4.conflictLoad", obsCnt[1], 3);
        checkOutput("t4.conflictCode", obsCode[1], 1);
        applyStimulus(1, 1, 0, 0, 7, 0);
        checkOutput("t4.codeKept", obsCode[1], 1);

        // Clear coinciding with a new firing keeps the new code.
        applyStimulus(1, 1, 0, 0, 6, 1);
        checkOutput("t4.clrVsFire", obsCode[1], 2);
        applyStimulus(1, 0, 0, 0, 0, 1);

        applyStimulus(1, 1, 0, 0, 4, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        checkOutput("t5.incDecHold", obsCnt[0], 4);
        checkOutput("t5.noError", obsErr[0], 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("t5.decWrap", obsCnt[0], 7);
        checkOutput("t5.decWrapPulse", obsWrap[0], 1);

        // Reset in the middle of counting.
        applyStimulus(1, 1, 0, 0, 2, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t6.resetCount", obsCnt[0], 0);
        checkOutput("t6.resetErr", obsErr[1], 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("t6.resume", obsCnt[0], 1);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 31) != 0),
                          ($urandom_range(0, 4) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0),
                          int'($urandom_range(0, 7)),
                          ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
